// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder: each stage ripples one SEG-bit slice.
// Define PRCA_OVF_EN to build the registered signed-overflow flag.
module pipelined_rca #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SEG;

  // Skew store: stage k keeps the WIDTH-(k+1)*SEG operand bits not yet added.
  function automatic int skoff(input int k);
    return SEG * (k * (STAGES - 1) - (k * (k - 1)) / 2);
  endfunction

  // Deskew store: stage k keeps the (k+1)*SEG finished low sum bits.
  function automatic int smoff(input int k);
    return SEG * ((k * (k + 1)) / 2);
  endfunction

  localparam int SKW = (STAGES > 1) ? skoff(STAGES - 1) : 1;
  localparam int SMW = smoff(STAGES);

  if (WIDTH % SEG != 0) begin : g_bad_cfg
    $error("pipelined_rca: WIDTH must be a multiple of SEG");
  end

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [SKW-1:0]    ska_q, ska_d;
  logic [SKW-1:0]    skb_q, skb_d;
  logic [SMW-1:0]    sm_q, sm_d;
  logic              stall;

`ifdef PRCA_OVF_EN
  logic ovf_d, ovf_q;
`endif

  assign stall     = v_q[STAGES-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign sum       = sm_q[smoff(STAGES-1) +: WIDTH];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0] xa, xb, sl;
    logic           ci, co;

    if (k == 0) begin : g_head
      assign xa            = a[SEG-1:0];
      assign xb            = b[SEG-1:0];
      assign ci            = cin;
      assign v_d[k]        = in_valid;
      assign sm_d[SEG-1:0] = sl;
    end else begin : g_body
      assign xa     = ska_q[skoff(k-1) +: SEG];
      assign xb     = skb_q[skoff(k-1) +: SEG];
      assign ci     = c_q[k-1];
      assign v_d[k] = v_q[k-1];
      assign sm_d[smoff(k) +: (k+1)*SEG] =
        {sl, sm_q[smoff(k-1) +: k*SEG]};
    end

    if (k < STAGES - 1) begin : g_skew
      localparam int RW = WIDTH - (k + 1) * SEG;
      if (k == 0) begin : g_load
        assign ska_d[RW-1:0] = a[WIDTH-1:SEG];
        assign skb_d[RW-1:0] = b[WIDTH-1:SEG];
      end else begin : g_shift
        assign ska_d[skoff(k) +: RW] =
          ska_q[skoff(k-1)+SEG +: RW];
        assign skb_d[skoff(k) +: RW] =
          skb_q[skoff(k-1)+SEG +: RW];
      end
    end

    always_comb begin : p_ripple
      logic cy;
      cy = ci;
      sl = '0;
      for (int i = 0; i < SEG; i++) begin
        sl[i] = xa[i] ^ xb[i] ^ cy;
        cy    = (xa[i] & xb[i]) | (cy & (xa[i] ^ xb[i]));
      end
      co = cy;
    end

    assign c_d[k] = co;

`ifdef PRCA_OVF_EN
    // The top slice holds the operand and sum sign bits.
    if (k == STAGES - 1) begin : g_ovf
      assign ovf_d = (xa[SEG-1] == xb[SEG-1]) &&
                     (sl[SEG-1] != xa[SEG-1]);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else if (!stall) begin
      v_q <= v_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      c_q   <= c_d;
      ska_q <= ska_d;
      skb_q <= skb_d;
      sm_q  <= sm_d;
    end
  end

`ifdef PRCA_OVF_EN
  always_ff @(posedge clk) begin
    if (!stall) begin
      ovf_q <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/pipelined_rca.md
PIPELINED_RCA -- requirements
Module: pipelined_rca

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 Parameter SEG, default 4: bits added per pipeline stage; WIDTH SHALL be an integer multiple of SEG, with STAGES = WIDTH/SEG.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  a, b and cin are valid this cycle.
REQ-006 in_ready  output  1  block accepts an input this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in to bit 0.
REQ-010 out_valid  output  1  sum, cout and ovf are valid.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of bit WIDTH-1.
REQ-014 ovf  output  1  signed overflow flag (see Configuration).

Function
REQ-015 The block SHALL be a STAGES-deep pipeline; stage k adds bits [k*SEG +: SEG] of the skewed operands using the carry registered by stage k-1, with stage 0 using cin.
REQ-016 The upper operand slices not yet consumed SHALL be carried in skew registers alongside each stage's valid bit; finished lower sum slices SHALL be carried forward in deskew registers.
REQ-017 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-018 stall = out_valid && !out_ready; in_ready SHALL equal !stall, combinationally.
REQ-019 While stall is asserted, every pipeline register, including the valid bits, SHALL hold its value.
REQ-020 Without a stall, latency from input transfer to out_valid SHALL be exactly STAGES cycles; throughput SHALL be one result per cycle.
REQ-021 Each stage valid bit SHALL advance on every non-stall cycle; stage 0 SHALL load in_valid.
REQ-022 An empty slot (valid=0) SHALL never assert out_valid, and bubbles SHALL propagate without corrupting neighbouring results.
REQ-023 Results SHALL leave the pipeline in input order, with no loss or duplication under any out_ready pattern.
REQ-024 sum, cout and ovf SHALL stay stable while out_valid && !out_ready.
REQ-025 Data registers need not be reset; only the valid bits are reset.
REQ-026 The carry chain within a stage SHALL be a ripple of SEG full adders; no carry-lookahead is permitted.

Reset
REQ-027 When rst=1 at a clock edge, all stage valid bits SHALL clear, so out_valid=0 and in_ready=1 on the following cycle.
REQ-028 An rst asserted mid-operation SHALL discard every in-flight result; no out_valid pulse SHALL appear for data accepted before the reset.
REQ-029 An input presented in the same cycle as rst=1 SHALL be discarded.
REQ-030 rst SHALL take priority over stall.

Configuration
REQ-031 Macro PRCA_OVF_EN: when defined, ovf SHALL be registered through the final stage as (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]) for the result it accompanies.
REQ-032 When PRCA_OVF_EN is undefined, ovf SHALL be tied to 0 and no overflow logic or registers SHALL be generated; all other behaviour SHALL be unchanged.

Verification (WIDTH=16, SEG=4, STAGES=4, out_ready=1 unless stated)
REQ-033 Reset, then a=0x0000, b=0x0000, cin=0 for one cycle -> out_valid exactly 4 cycles later with sum=0x0000, cout=0, ovf=0.
REQ-034 a=0xFFFF, b=0x0000, cin=1 (full carry ripple through all stages) -> sum=0x0000, cout=1; ovf=0.
REQ-035 With PRCA_OVF_EN defined, a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; the same stimulus with the macro undefined -> ovf=0.
REQ-036 Back-to-back inputs 0x0505+0x0A0A, 0xC00C+0xA00A, 0x0303+0x0707 (cin=1) -> results 0x0F0F/0, 0x6016/1, 0x0A0B/0 on consecutive cycles.
REQ-037 Random stream with out_ready held low for 3 cycles mid-stream -> in_ready=0 and outputs held during the hold, results in order, none lost, scoreboard matches.
REQ-038 rst pulsed while 3 results are in flight -> no out_valid for those results, and the next accepted input emerges after 4 cycles.
